// File: rtl/gauss_hblur_stream.sv
// Horizontal Gaussian blur over a multi-channel pixel stream with valid/ready flow control.
// Optional: define GAUSS_HBLUR_EDGE_REPLICATE_EN to replicate the first pixel of each line instead of zero padding.
module gauss_hblur_stream #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned CHANNELS   = 3,
   parameter int unsigned TAPS       = 5,
   parameter int unsigned COEF_W     = 9,
   parameter logic [TAPS*COEF_W-1:0] KERNEL = {9'd1, 9'd4, 9'd6, 9'd4, 9'd1},
   parameter int unsigned COEF_SHIFT = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CHANNELS*DATA_W-1:0] in_data,
   input  logic                       in_sop,
   input  logic                       in_sol,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CHANNELS*DATA_W-1:0] out_data,
   output logic                       out_sop,
   output logic                       out_sol
);

   localparam int unsigned PIX_W = CHANNELS * DATA_W;
   localparam int unsigned ACC_W = DATA_W + COEF_W + $clog2(TAPS);
   localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (COEF_SHIFT - 1);
   localparam logic [ACC_W-1:0] SAT = ACC_W'({DATA_W{1'b1}});

`ifdef GAUSS_HBLUR_EDGE_REPLICATE_EN
   localparam bit EDGE_REP = 1'b1;
`else
   localparam bit EDGE_REP = 1'b0;
`endif

   function automatic longint unsigned kernel_sum();
      longint unsigned s;
      s = 0;
      for (int i = 0; i < TAPS; i++) s += 64'(KERNEL[i*COEF_W +: COEF_W]);
      return s;
   endfunction

   // Reject kernels that cannot be normalised by a plain shift
   if ((TAPS % 2) == 0 || TAPS < 3 || TAPS > 13) begin : g_err_taps
      $error("gauss_hblur_stream: TAPS must be odd and within 3..13");
   end
   if (COEF_SHIFT == 0) begin : g_err_shift
      $error("gauss_hblur_stream: COEF_SHIFT must be non-zero");
   end
   if (kernel_sum() != (64'd1 << COEF_SHIFT)) begin : g_err_sum
      $error("gauss_hblur_stream: KERNEL sum must equal 2**COEF_SHIFT");
   end

   logic ce_c;
   logic accept_c;
   logic line_start_c;
   logic s1_v, s1_sop, s1_sol;
   logic s2_v, s2_sop, s2_sol;
   wire  [PIX_W-1:0] norm_all_c;

   assign ce_c         = !out_valid || out_ready;
   assign accept_c     = in_valid && ce_c;
   assign line_start_c = in_sol || in_sop;
   assign in_ready     = ce_c;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DATA_W-1:0] pix_c;
      logic [DATA_W-1:0] win [TAPS];
      logic [ACC_W-1:0]  mac_c;
      logic [ACC_W-1:0]  sum_r;
      logic [ACC_W-1:0]  rnd_c;
      logic [DATA_W-1:0] norm_c;

      assign pix_c = in_data[c*DATA_W +: DATA_W];

      // Window: a line start flushes older taps so lines never mix
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int t = 0; t < TAPS; t++) win[t] <= '0;
         end else if (accept_c) begin
            win[0] <= pix_c;
            for (int t = 1; t < TAPS; t++)
               win[t] <= line_start_c ? (EDGE_REP ? pix_c : '0) : win[t-1];
         end
      end

      always_comb begin
         mac_c = '0;
         for (int t = 0; t < TAPS; t++)
            mac_c += ACC_W'(win[t]) * ACC_W'(KERNEL[t*COEF_W +: COEF_W]);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)    sum_r <= '0;
         else if (ce_c) sum_r <= mac_c;
      end

      // Round-half-up then clamp to the pixel range
      always_comb begin
         rnd_c  = (sum_r + RND) >> COEF_SHIFT;
         norm_c = (rnd_c > SAT) ? SAT[DATA_W-1:0] : rnd_c[DATA_W-1:0];
      end

      assign norm_all_c[c*DATA_W +: DATA_W] = norm_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_sop    <= 1'b0;
         s1_sol    <= 1'b0;
         s2_v      <= 1'b0;
         s2_sop    <= 1'b0;
         s2_sol    <= 1'b0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_sol   <= 1'b0;
         out_data  <= '0;
      end else if (ce_c) begin
         s1_v      <= accept_c;
         s1_sop    <= in_sop && accept_c;
         s1_sol    <= in_sol && accept_c;
         s2_v      <= s1_v;
         s2_sop    <= s1_sop;
         s2_sol    <= s1_sol;
         out_valid <= s2_v;
         out_sop   <= s2_sop;
         out_sol   <= s2_sol;
         out_data  <= norm_all_c;
      end
   end

endmodule
